// File: rtl/seg7_scan_display.sv
// seg7_scan_display: scanned driver for NUM_DIGITS common-anode 7-segment digits.
// Optional feature macro SEG7_DP_EN adds the per-digit decimal point (dp port + shadow).
module seg7_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int DIV_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              hex,
  output logic [NUM_DIGITS-1:0]   an
`ifdef SEG7_DP_EN
  ,
  output logic                    dp
`endif
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Active-low gfedcba segment patterns for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic                    tick;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] data_q, data_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   sup;
  logic                    zero_above;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic [6:0]              hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  assign tick = (cnt_q == DIV_LAST);

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + DIV_W'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    data_d  = load ? data_in  : data_q;
    blank_d = load ? blank_in : blank_q;
  end

  // A digit is suppressed when it and every digit to its left hold zero; digit 0 never is.
  always_comb begin
    zero_above = 1'b1;
    sup        = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (data_q[4*i +: 4] == 4'h0);
      if (i > 0) begin
        sup[i] = lz_en & zero_above;
      end
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = data_q[4*i +: 4];
        cur_blank = blank_q[i] | sup[i];
      end
    end
    hex_d = cur_blank ? 7'h7F : decode(cur_nib);
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      blank_q <= '0;
      hex_q   <= 7'h7F;
      an_q    <= '1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      blank_q <= blank_d;
      hex_q   <= hex_d;
      an_q    <= an_d;
    end
  end

  assign hex = hex_q;
  assign an  = an_q;

`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0] dpsh_q, dpsh_d;
  logic                  cur_dp;
  logic                  dp_q, dp_d;

  always_comb begin
    dpsh_d = load ? dp_in : dpsh_q;
    cur_dp = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_dp = dpsh_q[i];
      end
    end
    // A dark digit keeps its decimal point dark too.
    dp_d = cur_blank ? 1'b1 : ~cur_dp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dpsh_q <= '0;
      dp_q   <= 1'b1;
    end else begin
      dpsh_q <= dpsh_d;
      dp_q   <= dp_d;
    end
  end

  assign dp = dp_q;
`else
  logic unused_dp_in;
  assign unused_dp_in = ^dp_in;
`endif

endmodule
